// File: rtl/samm_pkg.sv
// Shared constants and types for the samm result drain stage.
package samm_pkg;

  localparam int N       = 8;              // operand width
  localparam int M       = 8;              // matrix dimension
  localparam int ELEM_W  = 2 * N;          // result element width
  localparam int IDX_W   = $clog2(M);      // row/column tag width
  localparam int ELEMS   = M * M;          // elements per frame
  localparam int SEL_W   = $clog2(ELEMS);  // flat element index width
  localparam int FRAME_W = N * 2 * M * M;  // full result frame width

  // Read side: either nothing to send, or streaming the read bank.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/samm_frame_bank.sv
// One frame buffer: full frame register, full flag and element select mux.
module samm_frame_bank
  import samm_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               load,
  input  logic               clear,
  input  logic [FRAME_W-1:0] load_data,
  input  logic [IDX_W-1:0]   row,
  input  logic [IDX_W-1:0]   col,
  output logic               full,
  output logic [ELEM_W-1:0]  elem
);

  logic [FRAME_W-1:0] data_reg;
  logic               full_reg;
  logic [ELEM_W-1:0]  elems [ELEMS];
  logic [SEL_W-1:0]   sel;

  // Full flag; load beats clear so a recapture on the freeing beat keeps the bank occupied.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)        full_reg <= 1'b0;
    else if (load)  full_reg <= 1'b1;
    else if (clear) full_reg <= 1'b0;
  end

  // Frame storage; contents only matter while the full flag is set, so no reset.
  always_ff @(posedge Clk) begin
    if (load) data_reg <= load_data;
  end

  generate
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_elem
      assign elems[gi] = data_reg[gi*ELEM_W +: ELEM_W];
    end
  endgenerate

  // Row-major flat index of element (row, col).
  always_comb begin
    sel = SEL_W'(row) * SEL_W'(M) + SEL_W'(col);
  end

  assign elem = elems[sel];
  assign full = full_reg;

endmodule

// File: rtl/samm_result_drain.sv
// Double-buffered capture of samm result frames, streamed out one element per beat.
module samm_result_drain
  import samm_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_Dv,
  input  logic [FRAME_W-1:0] In_data,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [ELEM_W-1:0]  Out_Data,
  output logic [IDX_W-1:0]   Out_Row,
  output logic [IDX_W-1:0]   Out_Col,
  output logic               Out_Last,
  output logic               Busy,
  output logic               Overflow
);

  rd_state_t         state_reg, state_next;
  logic              wr_sel_reg, rd_sel_reg;
  logic [IDX_W-1:0]  row_reg, col_reg;
  logic              overflow_reg;
  logic [1:0]        bank_full, bank_load, bank_clear, full_next;
  logic [ELEM_W-1:0] bank_elem [2];
  logic              hs, at_last, last_hs, cap_ok, rd_sel_next;

  assign hs          = (state_reg == DRAIN) & Out_Ready;
  assign at_last     = (row_reg == IDX_W'(M-1)) && (col_reg == IDX_W'(M-1));
  assign last_hs     = hs & at_last;
  // A full write bank is still writable when its final beat leaves on this same edge.
  assign cap_ok      = In_Dv & (~bank_full[wr_sel_reg] | (last_hs & (rd_sel_reg == wr_sel_reg)));
  assign rd_sel_next = rd_sel_reg ^ last_hs;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_load[gi]  = cap_ok & (wr_sel_reg == 1'(gi));
      assign bank_clear[gi] = last_hs & (rd_sel_reg == 1'(gi));
      assign full_next[gi]  = bank_load[gi] | (bank_full[gi] & ~bank_clear[gi]);

      samm_frame_bank u_bank (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (bank_load[gi]),
        .clear     (bank_clear[gi]),
        .load_data (In_data),
        .row       (row_reg),
        .col       (col_reg),
        .full      (bank_full[gi]),
        .elem      (bank_elem[gi])
      );
    end
  endgenerate

  // Read FSM state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Drain whenever the bank that will be read next cycle holds a frame (no bubble between frames).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (full_next[rd_sel_next])  state_next = DRAIN;
      DRAIN:   if (!full_next[rd_sel_next]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat outputs come only from registered state and the stored frame.
  always_comb begin
    Out_Valid = 1'b0;
    Out_Data  = '0;
    Out_Row   = '0;
    Out_Col   = '0;
    Out_Last  = 1'b0;
    if (state_reg == DRAIN) begin
      Out_Valid = 1'b1;
      Out_Data  = bank_elem[rd_sel_reg];
      Out_Row   = row_reg;
      Out_Col   = col_reg;
      Out_Last  = at_last;
    end
  end

  // Row-major element position, advanced on each accepted beat.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (hs) begin
      if (col_reg == IDX_W'(M-1)) begin
        col_reg <= '0;
        row_reg <= at_last ? '0 : row_reg + IDX_W'(1);
      end else begin
        col_reg <= col_reg + IDX_W'(1);
      end
    end
  end

  // Bank selects and the sticky dropped-frame flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      rd_sel_reg <= rd_sel_next;
      if (cap_ok)          wr_sel_reg   <= ~wr_sel_reg;
      if (In_Dv & ~cap_ok) overflow_reg <= 1'b1;
    end
  end

  assign Busy     = |bank_full;
  assign Overflow = overflow_reg;

endmodule

// File: doc/samm_result_drain.md
Name: samm_result_drain

Overview:
- Downstream stage of the samm systolic matrix multiplier.
- Captures each wide result frame (Out_data, qualified by Out_Dv) into one of two frame banks.
- Streams the frame out one element per beat over a valid/ready interface, in row-major order, with row/col tags.
- Double buffering lets samm emit a new frame while the previous one is still draining.

Parameters:
N, 8, operand width; result element width is 2*N bits
M, 8, matrix dimension; frame holds M*M elements
(derived, not overridable) ELEM_W = 2*N; IDX_W = clog2(M); FRAME_W = N*2*M*M

Ports:
Clk        input   1        clock, all state on rising edge
Rst        input   1        asynchronous, active-high reset
In_Dv      input   1        frame strobe from samm Out_Dv
In_data    input   FRAME_W  frame from samm Out_data; element (r,c) at bits [(r*M+c)*ELEM_W +: ELEM_W]
Out_Valid  output  1        element beat valid
Out_Ready  input   1        consumer accepts beat
Out_Data   output  ELEM_W   element value
Out_Row    output  IDX_W    element row r
Out_Col    output  IDX_W    element column c
Out_Last   output  1        high on the beat carrying (M-1,M-1)
Busy       output  1        at least one bank full
Overflow   output  1        sticky: a frame was dropped

Behaviour:
- Reset (async assert, sync release):
  - bank_full[1:0]=0, wr_sel=0, rd_sel=0, row=col=0, Overflow=0.
  - Outputs: Out_Valid=0, Out_Last=0, Busy=0, Out_Data/Out_Row/Out_Col=0.
  - Reset mid-drain discards all buffered frames; no partial beats after release.
- Capture on In_Dv at edge k:
  - If bank[wr_sel] is empty: load In_data into it, set its full flag, toggle wr_sel.
  - Out_Valid rises in cycle k+1 if that bank is the read bank.
- Drop rule:
  - If bank[wr_sel] is full at edge k, the frame is discarded and Overflow is set (cleared only by Rst).
  - Exception: if that bank's Out_Last beat handshakes at the same edge, the capture wins, the bank stays full with new data, and there is no overflow.
- Read FSM, two states:
  - DRAIN: entered when bank_full[rd_sel]=1. Out_Valid=1; Out_Data = bank[rd_sel] element (row,col); Out_Row=row; Out_Col=col.
  - On handshake (Out_Valid & Out_Ready): col increments; when col wraps M-1→0, row increments.
  - On the last handshake: row=col=0, bank_full[rd_sel] cleared (unless recaptured per the exception above), rd_sel toggles. Stay in DRAIN if the other bank is full, giving back-to-back frames with no bubble; otherwise go to IDLE.
  - IDLE: Out_Valid=0, Out_Data=0. Go to DRAIN when bank_full[rd_sel] becomes 1.
- Valid/ready rules:
  - While Out_Valid=1 and Out_Ready=0, Out_Data/Row/Col/Last stay stable.
  - Out_Valid never drops before its handshake.
  - Out_Ready while Out_Valid=0 is ignored.
- Throughput and latency:
  - One element per cycle at full Ready; M*M beats per frame.
  - Minimum In_Dv spacing with no drops at full Ready is M*M cycles.
- Busy = |bank_full.
- Output paths are combinational muxes from registered state only; no In_* → Out_* combinational path.

Decomposition:
- Package samm_pkg: N, M, ELEM_W, IDX_W, FRAME_W constants; read-FSM state enum {IDLE, DRAIN}.
- Sub-module samm_frame_bank, instantiated twice:
  - FRAME_W register plus full flag.
  - Load/clear controls.
  - ELEM_W element-select mux indexed by (row,col).

Test Plan:
- Single frame, element (r,c)=16*r+c, Out_Ready=1, In_Dv pulsed at edge k → Out_Valid high in cycles k+1..k+64. Beats carry 0x0000,0x0001,…,0x0077 in row-major order. Out_Last only on beat 64 (0x0077, row=7, col=7). Busy falls after beat 64.
- Backpressure: same frame, Out_Ready toggling 1,0,0,1,… → every element appears exactly once, in order. Data/Row/Col are held across every Ready=0 cycle.
- Back-to-back: frame A, then frame B (all elements 0xBBBB) at k+10, Ready=1 → 128 contiguous beats, A then B, no gap; Out_Last at beats 64 and 128; Overflow=0.
- Overflow: Ready=0; three In_Dv pulses at k, k+1, k+2 → the third frame is dropped and Overflow=1. After Ready=1, exactly 128 beats (frames 1 and 2) are emitted; Overflow stays 1.
- Simultaneous free and capture: both banks full; In_Dv on the same edge as the Out_Last handshake of bank[wr_sel] → new frame captured, Overflow=0, 64 further beats with the new data.
- Reset mid-drain: Rst pulsed after beat 20 → Out_Valid=0 and Busy=0 immediately (async). After release, no beats until a new In_Dv, and the next frame starts at row=0, col=0.
